// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative mult/div sequencer owning HI/LO and the EX stall
// Divider state and datapath are present only when MULDIV_DIV_EN is defined.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ALUop,
  input  logic [5:0]       func,
  input  logic             valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd3;
`ifdef MULDIV_DIV_EN
  localparam logic [1:0] S_DIV  = 2'd2;
`endif

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
`ifdef MULDIV_DIV_EN
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
`endif

  logic [1:0]         r_state;
  logic               r_busy;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_sign;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_dec;
  logic               w_mult;
  logic               w_multu;
  logic               w_div;
  logic               w_divu;
  logic               w_start;
  logic               w_signed;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_mul_fix;

  assign w_dec   = valid && (ALUop == 2'b10);
  assign w_mult  = w_dec && (func == F_MULT);
  assign w_multu = w_dec && (func == F_MULTU);
`ifdef MULDIV_DIV_EN
  assign w_div   = w_dec && (func == F_DIV);
  assign w_divu  = w_dec && (func == F_DIVU);
`else
  assign w_div   = 1'b0;
  assign w_divu  = 1'b0;
`endif

  assign w_start  = (r_state == S_IDLE) && (w_mult || w_multu || w_div || w_divu);
  assign w_signed = w_mult || w_div;
  assign w_mag_a  = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_mag_b  = (w_signed && b[WIDTH-1]) ? -b : b;

  // Cycle T stalls combinationally; MUL/DIV cycles stall via the busy flop.
  assign stall  = rst_n && (w_start || r_busy);
  assign busy   = r_busy;
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign result = (func == F_MFHI) ? r_hi : ((func == F_MFLO) ? r_lo : {WIDTH{1'b0}});

  // Shift-add: low half holds the remaining multiplier bits, high half the partial sum.
  assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                    + (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};
  assign w_mul_fix  = r_sign ? -w_mul_next : w_mul_next;

`ifdef MULDIV_DIV_EN
  logic               r_rsign;
  logic               r_dz;
  logic [WIDTH-1:0]   r_a_orig;
  logic [WIDTH:0]     w_rem_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // Restoring divide: high half is the partial remainder, low half shifts dividend out and quotient in.
  assign w_rem_shift = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
  assign w_diff      = w_rem_shift - {1'b0, r_mcand};
  assign w_div_next  = w_diff[WIDTH] ? {w_rem_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0}
                                     : {w_diff[WIDTH-1:0],      r_prod[WIDTH-2:0], 1'b1};
  assign w_quo_fix   = r_sign  ? -w_div_next[WIDTH-1:0]       : w_div_next[WIDTH-1:0];
  assign w_rem_fix   = r_rsign ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_sign   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
`ifdef MULDIV_DIV_EN
      r_rsign  <= 1'b0;
      r_dz     <= 1'b0;
      r_a_orig <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mult || w_multu) begin
            r_mcand <= w_mag_a;
            r_prod  <= {{WIDTH{1'b0}}, w_mag_b};
            r_sign  <= w_mult && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_MUL;
          end
`ifdef MULDIV_DIV_EN
          else if (w_div || w_divu) begin
            r_mcand  <= w_mag_b;
            r_prod   <= {{WIDTH{1'b0}}, w_mag_a};
            r_sign   <= w_div && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_rsign  <= w_div && a[WIDTH-1];
            r_dz     <= (b == {WIDTH{1'b0}});
            r_a_orig <= a;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_DIV;
          end
`endif
        end
        S_MUL: begin
          r_prod <= w_mul_next;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_hi    <= w_mul_fix[2*WIDTH-1:WIDTH];
            r_lo    <= w_mul_fix[WIDTH-1:0];
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
`ifdef MULDIV_DIV_EN
        S_DIV: begin
          r_prod <= w_div_next;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_hi    <= r_dz ? r_a_orig : w_rem_fix;
            r_lo    <= r_dz ? {WIDTH{1'b1}} : w_quo_fix;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ALUop;
  logic [5:0]  func;
  logic        valid;
  logic [31:0] a, b;
  logic        stall, busy;
  logic [31:0] hi, lo, result;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] sb_q[$];
  logic [63:0] exp_hl;
  logic [63:0] last_hl;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ALUop(ALUop), .func(func), .valid(valid),
    .a(a), .b(b), .stall(stall), .busy(busy), .hi(hi), .lo(lo), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_mul(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    if (sgn) return sx * sy;
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic run_op(input logic [5:0] f, input logic [31:0] op_a, input logic [31:0] op_b,
                        output int ncyc, output logic bsy0, output logic bsy1);
    @(negedge clk);
    valid = 1'b1; ALUop = 2'b10; func = f; a = op_a; b = op_b;
    #1;
    ncyc = 0; bsy0 = busy; bsy1 = 1'b0;
    while (stall && ncyc < 100) begin
      ncyc++;
      @(negedge clk); #1;
      if (ncyc == 1) bsy1 = busy;
    end
  endtask

  task automatic release_ex();
    @(negedge clk);
    valid = 1'b0; func = 6'b0; ALUop = 2'b00;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b1; ALUop = 2'b10; func = F_MULT; a = 32'd3; b = 32'd4;
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
    @(negedge clk);
    rst_n = 1'b1; valid = 1'b0;
    @(negedge clk); #1;
    n_tests++; if (busy !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got busy=%b stall=%b expected 0/0", busy, stall); end
  endtask

  task automatic test_mult();
    int n; logic b0, b1;
    sb_q.push_back(64'hFFFFFFFF_FFFFFFFA);
    run_op(F_MULT, 32'hFFFFFFFE, 32'd3, n, b0, b1);
    exp_hl = sb_q.pop_front(); last_hl = exp_hl;
    n_tests++; if (n != 33) begin n_fail++; $display("FAIL mult_stall_cycles: got %0d expected 33", n); end
    n_tests++; if (b0 !== 1'b0 || b1 !== 1'b1) begin n_fail++; $display("FAIL mult_busy_timing: got T=%b T+1=%b expected 0/1", b0, b1); end
    n_tests++; if ({hi, lo} !== exp_hl) begin n_fail++; $display("FAIL mult_hilo: got %h expected %h", {hi, lo}, exp_hl); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_done_busy: got %b expected 0", busy); end
    release_ex();
    n_tests++; if (busy !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL mult_no_restart: got busy=%b stall=%b expected 0/0", busy, stall); end
  endtask

  task automatic test_multu();
    int n; logic b0, b1;
    sb_q.push_back(64'hFFFFFFFE_00000001);
    run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, n, b0, b1);
    exp_hl = sb_q.pop_front(); last_hl = exp_hl;
    n_tests++; if (n != 33) begin n_fail++; $display("FAIL multu_stall_cycles: got %0d expected 33", n); end
    n_tests++; if ({hi, lo} !== exp_hl) begin n_fail++; $display("FAIL multu_hilo: got %h expected %h", {hi, lo}, exp_hl); end
    release_ex();
  endtask

  task automatic test_mflo_interlock();
    int n;
    sb_q.push_back(64'h00000000_0000001E);
    @(negedge clk);
    valid = 1'b1; ALUop = 2'b10; func = F_MULT; a = 32'd5; b = 32'd6;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mflo_start_stall: got %b expected 1", stall); end
    @(negedge clk);
    func = F_MFLO; a = 32'd9; b = 32'd9;
    #1;
    n = 1;
    while (stall && n < 100) begin
      n++;
      @(negedge clk); #1;
    end
    exp_hl = sb_q.pop_front(); last_hl = exp_hl;
    n_tests++; if (n != 33) begin n_fail++; $display("FAIL mflo_interlock_cycles: got %0d expected 33", n); end
    n_tests++; if (result !== 32'd30) begin n_fail++; $display("FAIL mflo_result: got %h expected 1e", result); end
    n_tests++; if ({hi, lo} !== exp_hl) begin n_fail++; $display("FAIL mflo_hilo: got %h expected %h", {hi, lo}, exp_hl); end
    func = F_MFHI; #1;
    n_tests++; if (result !== 32'd0) begin n_fail++; $display("FAIL mfhi_result: got %h expected 0", result); end
    @(negedge clk);
    func = F_MFLO; #1;
    n_tests++; if (stall !== 1'b0 || busy !== 1'b0 || result !== 32'd30) begin
      n_fail++; $display("FAIL mflo_idle: got stall=%b busy=%b result=%h expected 0/0/1e", stall, busy, result);
    end
    release_ex();
  endtask

  task automatic test_back_to_back();
    int n; logic b0, b1;
    logic [31:0] xa, xb;
    logic [5:0]  f;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin xa = 32'h80000000; xb = 32'h80000000; end
      else begin xa = $urandom; xb = $urandom; end
      f = (i % 2 == 0) ? F_MULT : F_MULTU;
      sb_q.push_back(model_mul(f == F_MULT, xa, xb));
      run_op(f, xa, xb, n, b0, b1);
      exp_hl = sb_q.pop_front(); last_hl = exp_hl;
      n_tests++; if (n != 33 || b1 !== 1'b1) begin n_fail++; $display("FAIL b2b_timing[%0d]: got cycles=%0d busy1=%b expected 33/1", i, n, b1); end
      n_tests++; if ({hi, lo} !== exp_hl) begin n_fail++; $display("FAIL b2b_hilo[%0d]: got %h expected %h", i, {hi, lo}, exp_hl); end
    end
    release_ex();
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    int n; logic b0, b1;
    logic [5:0]  fv[5]  = '{F_DIV, F_DIVU, F_DIV, F_DIV, F_DIVU};
    logic [31:0] av[5]  = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd100, 32'hFFFFFFFF};
    logic [31:0] bv[5]  = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd10};
    logic [63:0] ev[5]  = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000064_FFFFFFFF, 64'h00000000_80000000,
                           64'h00000002_FFFFFFF2, 64'h00000005_19999999};
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(ev[i]);
      run_op(fv[i], av[i], bv[i], n, b0, b1);
      exp_hl = sb_q.pop_front(); last_hl = exp_hl;
      n_tests++; if (n != 33) begin n_fail++; $display("FAIL div_stall_cycles[%0d]: got %0d expected 33", i, n); end
      n_tests++; if ({hi, lo} !== exp_hl) begin n_fail++; $display("FAIL div_hilo[%0d]: got %h expected %h", i, {hi, lo}, exp_hl); end
    end
    release_ex();
  endtask
`else
  task automatic test_div_disabled();
    @(negedge clk);
    valid = 1'b1; ALUop = 2'b10; func = F_DIVU; a = 32'd100; b = 32'd0;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL divdis_stall: got %b expected 0", stall); end
    @(negedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL divdis_busy: got %b expected 0", busy); end
    n_tests++; if ({hi, lo} !== last_hl) begin n_fail++; $display("FAIL divdis_hilo: got %h expected %h", {hi, lo}, last_hl); end
    release_ex();
  endtask
`endif

  task automatic test_reset_mid();
    int n; logic b0, b1;
    logic [5:0] f;
`ifdef MULDIV_DIV_EN
    f = F_DIV;
`else
    f = F_MULT;
`endif
    @(negedge clk);
    valid = 1'b1; ALUop = 2'b10; func = f; a = 32'd1000; b = 32'd7;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++; if (stall !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got stall=%b busy=%b expected 0/0", stall, busy); end
    n_tests++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL rstmid_hilo: got %h expected 0", {hi, lo}); end
    @(negedge clk);
    rst_n = 1'b1; valid = 1'b0;
    sb_q.push_back(model_mul(1'b1, 32'hFFFFFB2E, 32'd5678));
    run_op(F_MULT, 32'hFFFFFB2E, 32'd5678, n, b0, b1);
    exp_hl = sb_q.pop_front(); last_hl = exp_hl;
    n_tests++; if (n != 33) begin n_fail++; $display("FAIL rstmid_new_cycles: got %0d expected 33", n); end
    n_tests++; if ({hi, lo} !== exp_hl) begin n_fail++; $display("FAIL rstmid_new_hilo: got %h expected %h", {hi, lo}, exp_hl); end
    release_ex();
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; ALUop = 2'b00; func = 6'b0; a = 32'b0; b = 32'b0;
    last_hl = 64'h0;
    test_reset();
    test_mult();
    test_multu();
    test_mflo_interlock();
    test_back_to_back();
`ifdef MULDIV_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
